// File: rtl/fabric_add_tag_mux.sv
// fabric_add_tag_mux
// Merges NUM_IN untagged producer channels onto one tagged output link.
// Each channel gets its own tag from cfg_data. A round-robin arbiter picks
// one valid channel per cycle, and a single output register holds the beat.
// Optional feature: define FABRIC_ADD_TAG_MUX_DUP_CHECK_EN to build a sticky
// duplicate-tag detector on err_dup_tag. Without it, err_dup_tag is tied low.
module fabric_add_tag_mux #(
    parameter int NUM_IN     = 4,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 4,
    localparam int IN_PW        = (DATA_WIDTH > 0) ? DATA_WIDTH : 1,
    localparam int OUT_PW       = DATA_WIDTH + TAG_WIDTH,
    localparam int CONFIG_WIDTH = NUM_IN * TAG_WIDTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_IN-1:0]          in_valid,
    output logic [NUM_IN-1:0]          in_ready,
    input  logic [NUM_IN*IN_PW-1:0]    in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [OUT_PW-1:0]          out_data,
    input  logic [CONFIG_WIDTH-1:0]    cfg_data,
    output logic                       err_dup_tag
);

    localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

    // ------------------------------------------------------------------
    // Elaboration-time parameter checks
    // ------------------------------------------------------------------
    generate
        if (NUM_IN < 2) begin : g_chk_num_in
            $fatal(1, "COMP_ADD_TAG_MUX_NUM_IN: NUM_IN must be >= 2");
        end
        if (TAG_WIDTH < 1) begin : g_chk_tag_width
            $fatal(1, "COMP_ADD_TAG_MUX_TAG_WIDTH: TAG_WIDTH must be >= 1");
        end
        if (DATA_WIDTH < 0) begin : g_chk_data_width
            $fatal(1, "COMP_ADD_TAG_MUX_DATA_WIDTH: DATA_WIDTH must be >= 0");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 out_valid_reg;
    logic [OUT_PW-1:0]    out_data_reg;
    logic [PTR_W-1:0]     rr_ptr_reg;
    logic [PTR_W-1:0]     rr_ptr_next;

    // ------------------------------------------------------------------
    // Handshake qualifiers
    // ------------------------------------------------------------------
    logic load_en;
    logic gnt_any;
    logic accept;

    assign load_en = !out_valid_reg || out_ready;
    assign gnt_any = |in_valid;
    assign accept  = load_en && gnt_any;

    // ------------------------------------------------------------------
    // Round-robin arbiter
    // Requests at or above rr_ptr win first (lowest index among them).
    // If none of those are valid, the search wraps to the lowest valid
    // index overall. The lowest set bit comes from the x & -x identity.
    // ------------------------------------------------------------------
    logic [NUM_IN-1:0] upper_mask;
    logic [NUM_IN-1:0] masked_req;
    logic [NUM_IN-1:0] masked_oh;
    logic [NUM_IN-1:0] full_oh;
    logic [NUM_IN-1:0] grant_oh;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_mask
            assign upper_mask[gi] = !(PTR_W'(gi) < rr_ptr_reg);
        end
    endgenerate

    assign masked_req = in_valid & upper_mask;
    assign masked_oh  = masked_req & (~masked_req + NUM_IN'(1));
    assign full_oh    = in_valid & (~in_valid + NUM_IN'(1));
    assign grant_oh   = (|masked_req) ? masked_oh : full_oh;

    // ------------------------------------------------------------------
    // One-hot grant to binary index, and the tagged word of the winner.
    // Both are built as OR chains, so only the granted channel contributes.
    // ------------------------------------------------------------------
    logic [NUM_IN:0][PTR_W-1:0]  idx_chain;
    logic [NUM_IN:0][OUT_PW-1:0] word_chain;
    logic [NUM_IN-1:0][OUT_PW-1:0] chan_word;
    logic [PTR_W-1:0]            grant_idx;
    logic [OUT_PW-1:0]           grant_word;

    assign idx_chain[0]  = '0;
    assign word_chain[0] = '0;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_chan
            if (DATA_WIDTH > 0) begin : g_payload
                assign chan_word[gi] = {cfg_data[gi*TAG_WIDTH +: TAG_WIDTH],
                                        in_data[gi*IN_PW +: IN_PW]};
            end else begin : g_tag_only
                // Payload-less link: the beat carries just the source tag.
                assign chan_word[gi] = cfg_data[gi*TAG_WIDTH +: TAG_WIDTH];
            end

            assign idx_chain[gi+1]  = idx_chain[gi]
                                    | (grant_oh[gi] ? PTR_W'(gi) : '0);
            assign word_chain[gi+1] = word_chain[gi]
                                    | (grant_oh[gi] ? chan_word[gi] : '0);
        end
    endgenerate

    assign grant_idx  = idx_chain[NUM_IN];
    assign grant_word = word_chain[NUM_IN];

    // Pointer moves to the channel just after the winner, wrapping at NUM_IN-1.
    assign rr_ptr_next = (grant_idx == PTR_W'(NUM_IN - 1)) ? '0
                       : grant_idx + PTR_W'(1);

    // Only the granted channel sees ready, and never while reset is held.
    assign in_ready = grant_oh & {NUM_IN{accept && rst_n}};

    // ------------------------------------------------------------------
    // Output register: load on accept, drop valid on an idle drain,
    // and hold everything (including the sampled tag) while stalled.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            rr_ptr_reg    <= '0;
        end else if (load_en) begin
            out_valid_reg <= gnt_any;
            if (gnt_any) begin
                out_data_reg <= grant_word;
                rr_ptr_reg   <= rr_ptr_next;
            end
        end
    end

    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;

    // ------------------------------------------------------------------
    // Duplicate-tag detector
    // Every unordered channel pair is compared. Only the upper triangle
    // is live; the rest is tied low, so each pair is counted once.
    // ------------------------------------------------------------------
`ifdef FABRIC_ADD_TAG_MUX_DUP_CHECK_EN
    logic [NUM_IN-1:0][NUM_IN-1:0] dup_pair;
    logic                          dup_any;
    logic                          err_reg;

    generate
        for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_dup_row
            for (genvar gj = 0; gj < NUM_IN; gj++) begin : g_dup_col
                if (gj > gi) begin : g_cmp
                    assign dup_pair[gi][gj] =
                        (cfg_data[gi*TAG_WIDTH +: TAG_WIDTH] ==
                         cfg_data[gj*TAG_WIDTH +: TAG_WIDTH]);
                end else begin : g_none
                    assign dup_pair[gi][gj] = 1'b0;
                end
            end
        end
    endgenerate

    assign dup_any = |dup_pair;

    // Sticky error: once any two channels share a tag, stay set until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_reg <= 1'b0;
        end else if (dup_any) begin
            err_reg <= 1'b1;
        end
    end

    assign err_dup_tag = err_reg;
`else
    assign err_dup_tag = 1'b0;
`endif

endmodule

// File: tb/tb_fabric_add_tag_mux.sv
// Testbench for fabric_add_tag_mux (NUM_IN=4, DATA_WIDTH=32, TAG_WIDTH=4).
// The driver issues directed vectors and pushes hand-computed beats into a
// queue. An independent monitor pops and compares on each output handshake.
module tb_fabric_add_tag_mux;

    localparam int NUM_IN = 4;
    localparam int DW     = 32;
    localparam int TW     = 4;
    localparam int OW     = DW + TW;

`ifdef FABRIC_ADD_TAG_MUX_DUP_CHECK_EN
    localparam logic EXP_DUP = 1'b1;
`else
    localparam logic EXP_DUP = 1'b0;
`endif

    logic                      clk;
    logic                      rst_n;
    logic [NUM_IN-1:0]         in_valid;
    logic [NUM_IN-1:0]         in_ready;
    logic [NUM_IN-1:0][DW-1:0] dat;
    logic                      out_valid;
    logic                      out_ready;
    logic [OW-1:0]             out_data;
    logic [NUM_IN*TW-1:0]      cfg_data;
    logic                      err_dup_tag;

    int checks = 0;
    int errors = 0;
    logic [OW-1:0] exp_q[$];

    fabric_add_tag_mux #(
        .NUM_IN     (NUM_IN),
        .DATA_WIDTH (DW),
        .TAG_WIDTH  (TW)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (dat),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .cfg_data    (cfg_data),
        .err_dup_tag (err_dup_tag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end else begin
            $display("ok   %s: %h", name, act);
        end
    endtask

    function automatic logic [OW-1:0] word(input logic [TW-1:0] tag, input logic [DW-1:0] d);
        return {tag, d};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every output handshake must match the oldest expected beat.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {28'd0, out_data}, 64'hDEAD);
            end else begin
                check("beat", {28'd0, out_data}, {28'd0, exp_q.pop_front()});
            end
        end
    end

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ch;
        rst_n     = 1'b0;
        in_valid  = 4'hF;
        out_ready = 1'b1;
        cfg_data  = 16'h0123;              // tags ch0..ch3 = 3,2,1,0
        for (int i = 0; i < NUM_IN; i++) dat[i] = DW'(i * 16);

        // Reset with all channels requesting
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_in_ready", {60'd0, in_ready}, 64'd0);
        check("rst_out_data", {28'd0, out_data}, 64'd0);
        check("rst_err", {63'd0, err_dup_tag}, 64'd0);
        tick();
        rst_n = 1'b1;

        // Round robin: ten accepts, ch0 first, ending with ch1 (pointer -> 2)
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            ch = k % 4;
            check("rr_in_ready", {60'd0, in_ready}, 64'(1 << ch));
            exp_q.push_back(word(TW'(3 - ch), DW'(ch * 16)));
            tick();
        end

        // Wrap/skip: only ch1 and ch3 valid with pointer at 2 -> 3, 1, 3
        in_valid = 4'b1010;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            ch = (k == 1) ? 1 : 3;
            check("skip_in_ready", {60'd0, in_ready}, 64'(1 << ch));
            exp_q.push_back(word(TW'(3 - ch), DW'(ch * 16)));
            tick();
        end

        // Idle drain: last beat visible for exactly one cycle
        in_valid = 4'b0000;
        @(negedge clk);
        check("drain_valid_hi", {63'd0, out_valid}, 64'd1);
        check("drain_in_ready", {60'd0, in_ready}, 64'd0);
        tick();
        @(negedge clk);
        check("drain_valid_lo", {63'd0, out_valid}, 64'd0);
        tick();

        // Backpressure: ch2 tag A data 55 held while out_ready=0
        cfg_data = 16'h0A23;
        dat[2]   = 32'h55;
        in_valid = 4'b0100;
        @(negedge clk);
        check("bp_accept_ready", {60'd0, in_ready}, 64'h4);
        exp_q.push_back(word(4'hA, 32'h55));
        tick();
        out_ready = 1'b0;
        dat[2]    = 32'h66;
        for (int s = 0; s < 5; s++) begin
            @(negedge clk);
            check("bp_in_ready", {60'd0, in_ready}, 64'd0);
            check("bp_valid", {63'd0, out_valid}, 64'd1);
            check("bp_hold_data", {28'd0, out_data}, {28'd0, word(4'hA, 32'h55)});
            tick();
            if (s == 1) cfg_data = 16'h0523;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", {60'd0, in_ready}, 64'h4);
        exp_q.push_back(word(4'h5, 32'h66));
        tick();
        in_valid = 4'b0000;
        @(negedge clk);
        check("bp_next_data", {28'd0, out_data}, {28'd0, word(4'h5, 32'h66)});
        tick();

        // Duplicate tag for a single cycle
        cfg_data = 16'h3211;
        @(negedge clk);
        check("dup_before", {63'd0, err_dup_tag}, 64'd0);
        tick();
        cfg_data = 16'h3210;
        for (int s = 0; s < 4; s++) begin
            @(negedge clk);
            check("dup_sticky", {63'd0, err_dup_tag}, {63'd0, EXP_DUP});
            tick();
        end

        // Reset mid-transfer: held beat from ch0 is discarded
        dat[0]    = 32'h77;
        in_valid  = 4'b0001;
        out_ready = 1'b0;
        @(negedge clk);
        check("mid_accept_ready", {60'd0, in_ready}, 64'h1);
        tick();
        @(negedge clk);
        check("mid_held", {28'd0, out_data}, {28'd0, word(4'h0, 32'h77)});
        tick();
        rst_n = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_ready", {60'd0, in_ready}, 64'd0);
        check("mid_rst_data", {28'd0, out_data}, 64'd0);
        check("mid_rst_err", {63'd0, err_dup_tag}, 64'd0);
        tick();
        rst_n     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("post_rst_ready", {60'd0, in_ready}, 64'h1);
        exp_q.push_back(word(4'h0, 32'h77));
        tick();
        in_valid = 4'b0000;
        repeat (3) tick();

        check("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
